// File: rtl/excp_ctrl.sv
// Exception / ERTN sequencer between commit and the CSR file.
// Takes a faulting, interrupted or ERTN commit, issues one-cycle CSR update strobes,
// flushes the pipeline, redirects fetch and holds commit off until the flush drains.
module excp_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        commit_valid,
   output logic        commit_ready,
   input  logic [31:0] commit_pc,
   input  logic [7:0]  commit_excp,
   input  logic [31:0] commit_badv,
   input  logic        commit_ertn,
   input  logic        int_pending,
   input  logic [31:0] csr_eentry,
   input  logic [31:0] csr_tlbrentry,
   input  logic [31:0] csr_era,
   input  logic [5:0]  csr_estat_ecode,
   output logic        excp_we,
   output logic [5:0]  excp_ecode,
   output logic [31:0] excp_era,
   output logic        excp_tlbr,
   output logic        badv_we,
   output logic [31:0] badv,
   output logic        ertn_we,
   output logic        ertn_tlbr,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam logic [5:0] EcodeTlbr = 6'h3F;

   typedef enum logic [1:0] {StIdle, StSave, StRedir, StDrain} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              is_excp_q, is_excp_d;
   logic              is_tlbr_q, is_tlbr_d;
   logic              badv_we_q, badv_we_d;
   logic [5:0]        ecode_q, ecode_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       badv_q, badv_d;

   logic              take;
   logic              dec_excp;
   logic              dec_tlbr;
   logic              dec_badv_we;
   logic [5:0]        dec_ecode;
   logic [31:0]       dec_badv;

   // Prioritise interrupt and exception causes of the committing instruction.
   always_comb begin
      dec_excp    = int_pending | (|commit_excp);
      dec_tlbr    = 1'b0;
      dec_badv_we = 1'b0;
      dec_badv    = commit_badv;
      dec_ecode   = 6'h0D;  // reserved-only cause treated as INE
      if (int_pending) begin
         dec_ecode = 6'h00;
      end else if (commit_excp[0]) begin
         dec_ecode   = 6'h08;
         dec_badv_we = 1'b1;
         dec_badv    = commit_pc;
      end else if (commit_excp[1]) begin
         dec_ecode   = EcodeTlbr;
         dec_tlbr    = 1'b1;
         dec_badv_we = 1'b1;
      end else if (commit_excp[2]) begin
         dec_ecode   = 6'h01;
         dec_badv_we = 1'b1;
      end else if (commit_excp[3]) begin
         dec_ecode = 6'h0D;
      end else if (commit_excp[4]) begin
         dec_ecode = 6'h0B;
      end else if (commit_excp[5]) begin
         dec_ecode = 6'h0C;
      end else if (commit_excp[6]) begin
         dec_ecode   = 6'h09;
         dec_badv_we = 1'b1;
      end
      take = commit_valid & (dec_excp | commit_ertn);
   end

   // Sequencer next state and Moore-style outputs; outputs are zero outside their slot.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      is_excp_d      = is_excp_q;
      is_tlbr_d      = is_tlbr_q;
      badv_we_d      = badv_we_q;
      ecode_d        = ecode_q;
      pc_d           = pc_q;
      badv_d         = badv_q;
      commit_ready   = 1'b0;
      excp_we        = 1'b0;
      excp_ecode     = 6'h00;
      excp_era       = 32'h0;
      excp_tlbr      = 1'b0;
      badv_we        = 1'b0;
      badv           = 32'h0;
      ertn_we        = 1'b0;
      ertn_tlbr      = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      unique case (state_q)
         StIdle: begin
            commit_ready = 1'b1;
            if (take) begin
               is_excp_d = dec_excp;
               is_tlbr_d = dec_excp & dec_tlbr;
               badv_we_d = dec_excp & dec_badv_we;
               ecode_d   = dec_ecode;
               pc_d      = commit_pc;
               badv_d    = dec_badv;
               state_d   = StSave;
            end
         end
         StSave: begin
            flush = 1'b1;
            if (is_excp_q) begin
               excp_we    = 1'b1;
               excp_ecode = ecode_q;
               excp_era   = pc_q;
               excp_tlbr  = is_tlbr_q;
               badv_we    = badv_we_q;
               badv       = badv_we_q ? badv_q : 32'h0;
            end else begin
               ertn_we   = 1'b1;
               ertn_tlbr = (csr_estat_ecode == EcodeTlbr);
            end
            state_d = StRedir;
         end
         StRedir: begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = is_tlbr_q ? csr_tlbrentry : (is_excp_q ? csr_eentry : csr_era);
            cnt_d          = CntW'(DRAIN_CYCLES);
            state_d        = (DRAIN_CYCLES == 0) ? StIdle : StDrain;
         end
         StDrain: begin
            flush = 1'b1;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and latched-cause registers; reset drops any in-flight sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         is_excp_q <= 1'b0;
         is_tlbr_q <= 1'b0;
         badv_we_q <= 1'b0;
         ecode_q   <= 6'h00;
         pc_q      <= 32'h0;
         badv_q    <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_excp_q <= is_excp_d;
         is_tlbr_q <= is_tlbr_d;
         badv_we_q <= badv_we_d;
         ecode_q   <= ecode_d;
         pc_q      <= pc_d;
         badv_q    <= badv_d;
      end
   end

endmodule

// File: tb/tb_excp_ctrl.sv
// Bench for excp_ctrl: DRAIN_CYCLES=2 and DRAIN_CYCLES=0 instances driven in lockstep.
module tb_excp_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic [7:0]  commit_excp;
   logic [31:0] commit_badv;
   logic        commit_ertn;
   logic        int_pending;
   logic [31:0] csr_eentry, csr_tlbrentry, csr_era;
   logic [5:0]  csr_estat_ecode;

   logic        a_rdy, a_ew, a_tl, a_bw, a_rw, a_rt, a_fl, a_rv;
   logic [5:0]  a_ec;
   logic [31:0] a_era, a_bv, a_rpc;
   logic        b_rdy, b_ew, b_tl, b_bw, b_rw, b_rt, b_fl, b_rv;
   logic [5:0]  b_ec;
   logic [31:0] b_era, b_bv, b_rpc;

   int nchecks = 0;
   int nerr    = 0;

   always #5 clk = ~clk;

   excp_ctrl #(.DRAIN_CYCLES(2)) u_a (
      .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_ready(a_rdy),
      .commit_pc(commit_pc), .commit_excp(commit_excp), .commit_badv(commit_badv),
      .commit_ertn(commit_ertn), .int_pending(int_pending), .csr_eentry(csr_eentry),
      .csr_tlbrentry(csr_tlbrentry), .csr_era(csr_era), .csr_estat_ecode(csr_estat_ecode),
      .excp_we(a_ew), .excp_ecode(a_ec), .excp_era(a_era), .excp_tlbr(a_tl),
      .badv_we(a_bw), .badv(a_bv), .ertn_we(a_rw), .ertn_tlbr(a_rt), .flush(a_fl),
      .redirect_valid(a_rv), .redirect_pc(a_rpc)
   );

   excp_ctrl #(.DRAIN_CYCLES(0)) u_b (
      .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_ready(b_rdy),
      .commit_pc(commit_pc), .commit_excp(commit_excp), .commit_badv(commit_badv),
      .commit_ertn(commit_ertn), .int_pending(int_pending), .csr_eentry(csr_eentry),
      .csr_tlbrentry(csr_tlbrentry), .csr_era(csr_era), .csr_estat_ecode(csr_estat_ecode),
      .excp_we(b_ew), .excp_ecode(b_ec), .excp_era(b_era), .excp_tlbr(b_tl),
      .badv_we(b_bw), .badv(b_bv), .ertn_we(b_rw), .ertn_tlbr(b_rt), .flush(b_fl),
      .redirect_valid(b_rv), .redirect_pc(b_rpc)
   );

   typedef struct {
      logic        valid;
      logic [7:0]  excp;
      logic        intp;
      logic        ertn;
      logic [31:0] pc;
      logic [31:0] badv;
      logic [31:0] eentry;
      logic [31:0] tlbrentry;
      logic [31:0] era;
      logic [5:0]  estat;
      logic        trig;
      logic        is_excp;
      logic [5:0]  ecode;
      logic        tlbr;
      logic        badv_we;
      logic [31:0] badv_e;
      logic        ertn_tlbr;
      logic [31:0] redir;
   } vec_t;

   localparam logic [31:0] E = 32'h1c008000;
   localparam logic [31:0] T = 32'h1c00f000;
   localparam logic [31:0] R = 32'h1c000204;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural reference: causes ranked by bit position, INT above all, exceptions over ERTN.
   function automatic vec_t model(input vec_t r);
      vec_t       o;
      logic [5:0] codes [7];
      logic       found;
      codes       = '{6'h08, 6'h3F, 6'h01, 6'h0D, 6'h0B, 6'h0C, 6'h09};
      o           = r;
      o.trig      = r.valid && (r.intp || (r.excp != 8'h0) || r.ertn);
      o.is_excp   = r.intp || (r.excp != 8'h0);
      o.ecode     = 6'h00;
      o.tlbr      = 1'b0;
      o.badv_we   = 1'b0;
      o.badv_e    = 32'h0;
      found       = 1'b0;
      if (!r.intp) begin
         for (int i = 0; i < 7; i++) begin
            if (!found && r.excp[i]) begin
               found     = 1'b1;
               o.ecode   = codes[i];
               o.tlbr    = (i == 1);
               o.badv_we = (i == 0) || (i == 1) || (i == 2) || (i == 6);
               o.badv_e  = (i == 0) ? r.pc : r.badv;
            end
         end
      end
      o.ertn_tlbr = !o.is_excp && (r.estat == 6'h3F);
      o.redir     = o.is_excp ? (o.tlbr ? r.tlbrentry : r.eentry) : r.era;
      return o;
   endfunction

   task automatic chk_dut(input string tag, input int k, input int drain, input vec_t r,
                          input logic rdy, input logic fl, input logic ew, input logic [5:0] ec,
                          input logic [31:0] era_o, input logic tl, input logic bw,
                          input logic [31:0] bv, input logic rw, input logic rt,
                          input logic rv, input logic [31:0] rpc);
      logic busy, s1, s2;
      busy = r.trig && (k >= 1) && (k <= 2 + drain);
      s1   = r.trig && (k == 1);
      s2   = r.trig && (k == 2);
      chk({tag, ".ready"}, 32'(rdy), 32'(!busy));
      chk({tag, ".flush"}, 32'(fl), 32'(busy));
      chk({tag, ".excp_we"}, 32'(ew), 32'(s1 && r.is_excp));
      if (s1 && r.is_excp) begin
         chk({tag, ".ecode"}, 32'(ec), 32'(r.ecode));
         chk({tag, ".era"}, era_o, r.pc);
         chk({tag, ".excp_tlbr"}, 32'(tl), 32'(r.tlbr));
      end
      chk({tag, ".badv_we"}, 32'(bw), 32'(s1 && r.badv_we));
      if (s1 && r.badv_we) chk({tag, ".badv"}, bv, r.badv_e);
      chk({tag, ".ertn_we"}, 32'(rw), 32'(s1 && !r.is_excp));
      chk({tag, ".ertn_tlbr"}, 32'(rt), 32'(s1 && r.ertn_tlbr));
      chk({tag, ".redirect_valid"}, 32'(rv), 32'(s2));
      if (s2) chk({tag, ".redirect_pc"}, rpc, r.redir);
   endtask

   task automatic chk_both(input int k, input vec_t r);
      chk_dut("d2", k, 2, r, a_rdy, a_fl, a_ew, a_ec, a_era, a_tl, a_bw, a_bv, a_rw, a_rt,
              a_rv, a_rpc);
      chk_dut("d0", k, 0, r, b_rdy, b_fl, b_ew, b_ec, b_era, b_tl, b_bw, b_bv, b_rw, b_rt,
              b_rv, b_rpc);
   endtask

   task automatic drive(input vec_t r);
      commit_valid    = r.valid;
      commit_excp     = r.excp;
      int_pending     = r.intp;
      commit_ertn     = r.ertn;
      commit_pc       = r.pc;
      commit_badv     = r.badv;
      csr_eentry      = r.eentry;
      csr_tlbrentry   = r.tlbrentry;
      csr_era         = r.era;
      csr_estat_ecode = r.estat;
   endtask

   // Present one commit for one cycle, then follow it for five cycles on both instances.
   task automatic run_txn(input vec_t r);
      @(posedge clk);
      #1;
      drive(r);
      @(negedge clk);
      chk_both(0, r);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         commit_valid = 1'b0;
         int_pending  = 1'($urandom);  // must be ignored while busy
         @(negedge clk);
         chk_both(k, r);
      end
      int_pending = 1'b0;
   endtask

   vec_t tbl [13];
   vec_t rv_t;
   vec_t idle_v;

   initial begin
      tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 32'h1c000100, 32'h0, E, T, R, 6'h00,
                  1'b1, 1'b1, 6'h0B, 1'b0, 1'b0, 32'h0, 1'b0, E};
      tbl[1]  = '{1'b1, 8'h48, 1'b0, 1'b0, 32'h1c000110, 32'h8003, E, T, R, 6'h00,
                  1'b1, 1'b1, 6'h0D, 1'b0, 1'b0, 32'h0, 1'b0, E};
      tbl[2]  = '{1'b1, 8'h40, 1'b0, 1'b0, 32'h1c000120, 32'h8003, E, T, R, 6'h00,
                  1'b1, 1'b1, 6'h09, 1'b0, 1'b1, 32'h8003, 1'b0, E};
      tbl[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 32'h1c000130, 32'hdead0000, E, T, R, 6'h00,
                  1'b1, 1'b1, 6'h3F, 1'b1, 1'b1, 32'hdead0000, 1'b0, T};
      tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b1, 32'h1c000140, 32'h0, E, T, R, 6'h3F,
                  1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 32'h0, 1'b0, E};
      tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 32'h1c000150, 32'h0, E, T, R, 6'h3F,
                  1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0, 1'b1, R};
      tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 32'h1c000160, 32'h0, E, T, R, 6'h05,
                  1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0, 1'b0, R};
      tbl[7]  = '{1'b1, 8'h05, 1'b0, 1'b0, 32'h1c000300, 32'h1234, E, T, R, 6'h00,
                  1'b1, 1'b1, 6'h08, 1'b0, 1'b1, 32'h1c000300, 1'b0, E};
      tbl[8]  = '{1'b1, 8'h04, 1'b0, 1'b0, 32'h1c000310, 32'h4444, E, T, R, 6'h00,
                  1'b1, 1'b1, 6'h01, 1'b0, 1'b1, 32'h4444, 1'b0, E};
      tbl[9]  = '{1'b1, 8'h20, 1'b0, 1'b1, 32'h1c000320, 32'h0, E, T, R, 6'h3F,
                  1'b1, 1'b1, 6'h0C, 1'b0, 1'b0, 32'h0, 1'b0, E};
      tbl[10] = '{1'b0, 8'h10, 1'b1, 1'b1, 32'h1c000330, 32'h0, E, T, R, 6'h00,
                  1'b0, 1'b1, 6'h00, 1'b0, 1'b0, 32'h0, 1'b0, E};
      tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h1c000340, 32'h0, E, T, R, 6'h00,
                  1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0, 1'b0, R};
      tbl[12] = '{1'b1, 8'h03, 1'b1, 1'b0, 32'h1c000350, 32'h77, E, T, R, 6'h00,
                  1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 32'h0, 1'b0, E};
      idle_v  = tbl[11];
      idle_v.valid = 1'b0;

      rst = 1'b1;
      drive(idle_v);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_both(0, idle_v);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 13; i++) run_txn(tbl[i]);

      // Reset while in SAVE: strobe seen that cycle, then idle with no redirect replayed.
      @(posedge clk);
      #1;
      drive(tbl[0]);
      @(posedge clk);
      #1;
      commit_valid = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      chk("rst.save_excp_we", 32'(a_ew), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_both(0, idle_v);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst.no_redirect_d2", 32'(a_rv), 32'h0);
         chk("rst.no_redirect_d0", 32'(b_rv), 32'h0);
         chk("rst.flush_d2", 32'(a_fl), 32'h0);
      end

      for (int n = 0; n < 250; n++) begin
         rv_t.valid     = ($urandom_range(0, 9) != 0);
         rv_t.excp      = ($urandom_range(0, 2) == 0) ? 8'h00 :
                          (8'($urandom) & 8'($urandom) & 8'h7F);
         rv_t.intp      = ($urandom_range(0, 3) == 0);
         rv_t.ertn      = ($urandom_range(0, 2) == 0);
         rv_t.pc        = $urandom;
         rv_t.badv      = $urandom;
         rv_t.eentry    = $urandom;
         rv_t.tlbrentry = $urandom;
         rv_t.era       = $urandom;
         rv_t.estat     = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom);
         run_txn(model(rv_t));
      end

      $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
      $finish;
   end

endmodule
